// File: rtl/imem_pkg.sv
// Shared definitions for the instruction memory: boot image, its length,
// and the boot/run state encoding used by imem_sync.
package imem_pkg;

    localparam int BOOT_LEN = 10;

    localparam logic [15:0] BOOT_IMAGE [BOOT_LEN] = '{
        16'h4864, 16'h4A0A, 16'h4C50, 16'h4F96, 16'h0880,
        16'h5614, 16'h6180, 16'h6848, 16'h8820, 16'h4F94
    };

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Word loaded at a given boot position: image contents, then zero fill.
    function automatic logic [15:0] boot_word(input int unsigned idx);
        if (idx < BOOT_LEN) begin
            return BOOT_IMAGE[idx[3:0]];
        end
        return 16'h0000;
    endfunction

endpackage

// File: rtl/imem_ram.sv
// Simple dual-port synchronous RAM: one write port, one read port with a
// registered read output that only updates when a read is requested.
module imem_ram #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 256,
    parameter int AW     = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata_q
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Write and registered read; holding rdata_q when idle keeps stalled responses stable.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem[raddr];
        end
    end

endmodule

// File: rtl/imem_sync.sv
// Instruction memory with boot loader, program port and a 1- or 2-stage
// valid/ready read pipeline. Out-of-range fetches return zero with an error flag.
module imem_sync
    import imem_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 16,
    parameter int DEPTH   = 256,
    parameter int LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    output logic              busy
);

    localparam int RAM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   boot_ptr_q, boot_ptr_d;
    logic                busy_q, busy_d;
    logic                s1_valid_q, s1_valid_d;
    logic                s1_err_q, s1_err_d;
    logic                s2_valid_q, s2_valid_d;
    logic                s2_err_q, s2_err_d;
    logic [DATA_W-1:0]   s2_data_q, s2_data_d;

    logic                adv;
    logic                accept;
    logic                req_in_range;
    logic                prog_in_range;
    logic [DATA_W-1:0]   s1_data;

    logic                ram_we;
    logic [RAM_AW-1:0]   ram_waddr;
    logic [DATA_W-1:0]   ram_wdata;
    logic                ram_re;
    logic [RAM_AW-1:0]   ram_raddr;
    logic [DATA_W-1:0]   ram_rdata;

    imem_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (RAM_AW)
    ) u_ram (
        .clk     (clk),
        .we      (ram_we),
        .waddr   (ram_waddr),
        .wdata   (ram_wdata),
        .re      (ram_re),
        .raddr   (ram_raddr),
        .rdata_q (ram_rdata)
    );

    // Response port: pick the last pipeline stage; stage-1 data is masked to zero unless it is a valid in-range read.
    always_comb begin
        s1_data = (s1_valid_q && !s1_err_q) ? ram_rdata : '0;
        if (LATENCY == 2) begin
            rsp_valid = s2_valid_q;
            rsp_data  = s2_data_q;
            rsp_err   = s2_err_q;
        end else begin
            rsp_valid = s1_valid_q;
            rsp_data  = s1_data;
            rsp_err   = s1_err_q;
        end
        busy = busy_q;
    end

    // Handshake: the whole pipeline moves together, and a program write steals the cycle from fetches.
    always_comb begin
        adv           = !rsp_valid || rsp_ready;
        req_in_range  = 32'(req_addr) < 32'(DEPTH);
        prog_in_range = 32'(prog_addr) < 32'(DEPTH);
        req_ready     = (state_q == RUN) && !prog_we && adv;
        accept        = req_valid && req_ready;
    end

    // RAM port steering: boot loader owns the write port in BOOT, the program port in RUN.
    always_comb begin
        if (state_q == BOOT) begin
            ram_we    = !reset;
            ram_waddr = boot_ptr_q[RAM_AW-1:0];
            ram_wdata = DATA_W'(boot_word(32'(boot_ptr_q)));
        end else begin
            ram_we    = !reset && prog_we && prog_in_range;
            ram_waddr = prog_addr[RAM_AW-1:0];
            ram_wdata = prog_data;
        end
        ram_re    = accept && req_in_range;
        ram_raddr = req_addr[RAM_AW-1:0];
    end

    // Next-state logic for the boot/run FSM and the read pipeline stages.
    always_comb begin
        state_d    = state_q;
        boot_ptr_d = boot_ptr_q;
        if (state_q == BOOT) begin
            if (32'(boot_ptr_q) == 32'(DEPTH - 1)) begin
                state_d    = RUN;
                boot_ptr_d = '0;
            end else begin
                boot_ptr_d = boot_ptr_q + ADDR_W'(1);
            end
        end
        busy_d = (state_d == BOOT);

        s1_valid_d = s1_valid_q;
        s1_err_d   = s1_err_q;
        s2_valid_d = s2_valid_q;
        s2_err_d   = s2_err_q;
        s2_data_d  = s2_data_q;
        if (adv) begin
            s1_valid_d = accept;
            s1_err_d   = accept && !req_in_range;
            s2_valid_d = s1_valid_q;
            s2_err_d   = s1_err_q;
            s2_data_d  = s1_data;
        end
    end

    // State registers; reset restarts the boot load and flushes anything in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= BOOT;
            boot_ptr_q <= '0;
            busy_q     <= 1'b1;
            s1_valid_q <= 1'b0;
            s1_err_q   <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_err_q   <= 1'b0;
            s2_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            boot_ptr_q <= boot_ptr_d;
            busy_q     <= busy_d;
            s1_valid_q <= s1_valid_d;
            s1_err_q   <= s1_err_d;
            s2_valid_q <= s2_valid_d;
            s2_err_q   <= s2_err_d;
            s2_data_q  <= s2_data_d;
        end
    end

endmodule
